// File: rtl/tile_writer.sv
// Host front end for the tile map: queues tile updates and commits them, or whole-map fills, only during vblank.
// Optional macro TILE_WRITER_AUTOINC_EN: the index register steps by one after every addr-1 push.
//
// state | meaning
// IDLE  | nothing to commit
// DRAIN | popping queued updates, one per vblank cycle
// FILL  | writing the fill value to every tile, one per vblank cycle
module tile_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_TILES  = 4800,
    parameter int IDX_W      = 13,
    parameter int ID_W       = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   writedata,
    input  logic                          write,
    input  logic                          chipselect,
    input  logic [2:0]                    address,
    input  logic                          vblank,
    output logic                          tm_we,
    output logic [IDX_W-1:0]              tm_addr,
    output logic [ID_W-1:0]               tm_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          range_err
);

    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                ENT_W       = IDX_W + ID_W;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_TILES - 1);
    localparam logic [IDX_W:0]    NUM_TILES_W = (IDX_W + 1)'(NUM_TILES);
    localparam logic [PTR_W:0]    FULL_CNT    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [ID_W-1:0]     fill_val_q, fill_val_d;
    logic                ovf_q, ovf_d;
    logic                rerr_q, rerr_d;
    logic                tm_we_q, tm_we_d;
    logic [IDX_W-1:0]    tm_addr_q, tm_addr_d;
    logic [ID_W-1:0]     tm_data_q, tm_data_d;

    logic                host_wr, wr_idx, wr_push, fill_cmd, wr_clr;
    logic                push_range_bad, push_full, push_ok;
    logic                pop, fill_wr, fill_last;
    logic [ENT_W-1:0]    head;
    logic                unused_wdata;

    assign host_wr  = write & chipselect;
    assign wr_idx   = host_wr & (address == 3'd0);
    assign wr_push  = host_wr & (address == 3'd1);
    assign fill_cmd = host_wr & (address == 3'd2);
    assign wr_clr   = host_wr & (address == 3'd3) & writedata[0];

    assign unused_wdata = ^writedata[15:IDX_W];

    // Range is checked before fullness; a same-cycle fill empties the queue, so it never counts as full.
    assign push_range_bad = wr_push & ({1'b0, idx_q} >= NUM_TILES_W);
    assign push_full      = wr_push & ~push_range_bad & ~fill_cmd & (count_q == FULL_CNT);
    assign push_ok        = wr_push & ~push_range_bad & ~push_full;

    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_DRAIN;
            S_DRAIN: if (count_q == '0) state_d = S_IDLE;
            S_FILL:  if (fill_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fill_cmd) begin
            state_d = S_FILL;
        end
    end

    always_comb begin
        pop     = 1'b0;
        fill_wr = 1'b0;
        case (state_q)
            S_DRAIN: pop     = vblank & (count_q != '0) & ~fill_cmd;
            S_FILL:  fill_wr = vblank & ~fill_cmd;
            default: ;
        endcase
    end

    assign fill_last = fill_wr & (fill_cnt_q == LAST_IDX);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fill_cmd) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = push_ok ? (PTR_W + 1)'(1) : '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (wr_idx) begin
            idx_d = writedata[IDX_W-1:0];
        end
`ifdef TILE_WRITER_AUTOINC_EN
        else if (wr_push) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
`endif
    end

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        fill_val_d = fill_val_q;
        if (fill_cmd) begin
            fill_cnt_d = '0;
            fill_val_d = writedata[ID_W-1:0];
        end else if (fill_wr) begin
            fill_cnt_d = fill_last ? '0 : fill_cnt_q + 1'b1;
        end
    end

    // A flag set in the same cycle as a clear wins.
    always_comb begin
        ovf_d  = ovf_q;
        rerr_d = rerr_q;
        if (wr_clr) begin
            ovf_d  = 1'b0;
            rerr_d = 1'b0;
        end
        if (push_full) begin
            ovf_d = 1'b1;
        end
        if (push_range_bad) begin
            rerr_d = 1'b1;
        end
    end

    always_comb begin
        tm_we_d   = pop | fill_wr;
        tm_addr_d = tm_addr_q;
        tm_data_d = tm_data_q;
        if (pop) begin
            {tm_addr_d, tm_data_d} = head;
        end else if (fill_wr) begin
            tm_addr_d = fill_cnt_q;
            tm_data_d = fill_val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {idx_q, writedata[ID_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            fill_cnt_q <= '0;
            fill_val_q <= '0;
            ovf_q      <= 1'b0;
            rerr_q     <= 1'b0;
            tm_we_q    <= 1'b0;
            tm_addr_q  <= '0;
            tm_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            fill_cnt_q <= fill_cnt_d;
            fill_val_q <= fill_val_d;
            ovf_q      <= ovf_d;
            rerr_q     <= rerr_d;
            tm_we_q    <= tm_we_d;
            tm_addr_q  <= tm_addr_d;
            tm_data_q  <= tm_data_d;
        end
    end

    assign tm_we      = tm_we_q;
    assign tm_addr    = tm_addr_q;
    assign tm_data    = tm_data_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign range_err  = rerr_q;
    assign busy       = (state_q != S_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_tile_writer.sv
// Self-checking bench for tile_writer: randomized host writes against a queue-based model of the tile-map write stream.
module tb_tile_writer;
    localparam int FIFO_DEPTH = 16;
    localparam int NUM_TILES  = 4800;
    localparam int IDX_W      = 13;
    localparam int ID_W       = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] writedata = '0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = '0;
    logic        vblank = 1'b0;
    logic        tm_we;
    logic [IDX_W-1:0] tm_addr;
    logic [ID_W-1:0]  tm_data;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        range_err;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    tile_writer #(.FIFO_DEPTH(FIFO_DEPTH), .NUM_TILES(NUM_TILES), .IDX_W(IDX_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(chipselect),
        .address(address), .vblank(vblank), .tm_we(tm_we), .tm_addr(tm_addr), .tm_data(tm_data),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow), .range_err(range_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    always @(posedge clk) begin
        #1;
        if (tm_we === 1'b1) begin
            obs_addr.push_back(int'(tm_addr));
            obs_data.push_back(int'(tm_data));
            obs_cyc.push_back(cyc);
        end
    end

    // Reference model: index register, pending queue, sticky flags.
    int mdl_idx = 0;
    int mdl_qa[$];
    int mdl_qd[$];
    bit mdl_ovf = 0;
    bit mdl_rerr = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic obs_clear();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic host_write(input int a, input int d, input bit cs, output int acc);
        @(negedge clk);
        address = 3'(a); writedata = 16'(d); write = 1'b1; chipselect = cs;
        @(posedge clk); #1;
        acc = cyc;
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic do_idx(input int i);
        int acc;
        host_write(0, i, 1'b1, acc);
        mdl_idx = i;
    endtask

    task automatic do_push(input int id, output int acc);
        host_write(1, id, 1'b1, acc);
        if (mdl_idx >= NUM_TILES) mdl_rerr = 1;
        else if (mdl_qa.size() == FIFO_DEPTH) mdl_ovf = 1;
        else begin mdl_qa.push_back(mdl_idx); mdl_qd.push_back(id); end
`ifdef TILE_WRITER_AUTOINC_EN
        mdl_idx = (mdl_idx == NUM_TILES - 1) ? 0 : (mdl_idx + 1) % (1 << IDX_W);
`endif
    endtask

    task automatic do_fill(input int v);
        int acc;
        host_write(2, v, 1'b1, acc);
        mdl_qa.delete(); mdl_qd.delete();
    endtask

    task automatic do_clear();
        int acc;
        host_write(3, 1, 1'b1, acc);
        mdl_ovf = 0; mdl_rerr = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tm_we !== 1'b0) begin n_errors++; $display("FAIL reset_tm_we: got %0d expected 0", tm_we); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %0d expected 0", overflow); end
        n_checks++; if (range_err !== 1'b0) begin n_errors++; $display("FAIL reset_range_err: got %0d expected 0", range_err); end
        @(negedge clk);
        reset = 1'b1;
        mdl_idx = 0; mdl_qa.delete(); mdl_qd.delete(); mdl_ovf = 0; mdl_rerr = 0;
    endtask

    task automatic test_single();
        int acc; bit ok;
        vblank = 1'b1;
        obs_clear();
        do_idx(35);
        do_push(23, acc);
        wait_idle(30, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_idle: got busy expected idle"); end
        n_checks++; if (obs_addr.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", obs_addr.size()); end
        if (obs_addr.size() >= 1) begin
            n_checks++; if (obs_addr[0] != mdl_qa[0] || obs_data[0] != mdl_qd[0]) begin
                n_errors++; $display("FAIL single_entry: got (%0d,%0d) expected (%0d,%0d)", obs_addr[0], obs_data[0], mdl_qa[0], mdl_qd[0]);
            end
            n_checks++; if (obs_cyc[0] != acc + 2) begin n_errors++; $display("FAIL single_latency: got %0d expected %0d", obs_cyc[0], acc + 2); end
        end
        n_checks++; if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL single_count_zero: got %0d expected 0", fifo_count); end
        mdl_qa.delete(); mdl_qd.delete();
    endtask

    task automatic test_overflow();
        int acc, bad; bit ok;
        vblank = 1'b0;
        do_clear();
        obs_clear();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            do_idx(int'($urandom_range(0, NUM_TILES - 1)));
            do_push(int'($urandom_range(0, 63)), acc);
        end
        repeat (3) @(negedge clk);
        n_checks++; if (int'(fifo_count) != mdl_qa.size()) begin n_errors++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, mdl_qa.size()); end
        n_checks++; if (overflow !== mdl_ovf) begin n_errors++; $display("FAIL ovf_flag: got %0d expected %0d", overflow, mdl_ovf); end
        n_checks++; if (obs_addr.size() != 0) begin n_errors++; $display("FAIL ovf_no_write: got %0d expected 0", obs_addr.size()); end
        vblank = 1'b1;
        wait_idle(200, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ovf_idle: got busy expected idle"); end
        n_checks++; if (obs_addr.size() != mdl_qa.size()) begin n_errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", obs_addr.size(), mdl_qa.size()); end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < mdl_qa.size(); i++)
            if (obs_addr[i] != mdl_qa[i] || obs_data[i] != mdl_qd[i]) bad++;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL ovf_drain_order: got %0d bad entries expected 0", bad); end
        mdl_qa.delete(); mdl_qd.delete();
        do_clear();
        @(negedge clk);
        n_checks++; if (overflow !== mdl_ovf) begin n_errors++; $display("FAIL ovf_clear: got %0d expected %0d", overflow, mdl_ovf); end
    endtask

    task automatic test_range();
        int acc; bit ok;
        vblank = 1'b1;
        do_clear();
        obs_clear();
        do_idx(NUM_TILES);
        do_push(5, acc);
        host_write(1, 9, 1'b0, acc);
        host_write(5, 9, 1'b1, acc);
        repeat (5) @(negedge clk);
        n_checks++; if (range_err !== mdl_rerr) begin n_errors++; $display("FAIL range_flag: got %0d expected %0d", range_err, mdl_rerr); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL range_count: got %0d expected 0", fifo_count); end
        n_checks++; if (obs_addr.size() != 0) begin n_errors++; $display("FAIL range_no_write: got %0d expected 0", obs_addr.size()); end
        do_idx(NUM_TILES - 1);
        do_push(9, acc);
        wait_idle(30, ok);
        n_checks++; if (obs_addr.size() != 1) begin n_errors++; $display("FAIL range_edge_count: got %0d expected 1", obs_addr.size()); end
        if (obs_addr.size() >= 1) begin
            n_checks++; if (obs_addr[0] != NUM_TILES - 1 || obs_data[0] != 9) begin
                n_errors++; $display("FAIL range_edge_entry: got (%0d,%0d) expected (%0d,9)", obs_addr[0], obs_data[0], NUM_TILES - 1);
            end
        end
        mdl_qa.delete(); mdl_qd.delete();
        do_clear();
        @(negedge clk);
        n_checks++; if (range_err !== mdl_rerr) begin n_errors++; $display("FAIL range_clear: got %0d expected %0d", range_err, mdl_rerr); end
    endtask

    task automatic test_random_drain(input int iters);
        int acc, n, bad; bit ok;
        for (int it = 0; it < iters; it++) begin
            vblank = 1'b0;
            do_clear();
            obs_clear();
            n = int'($urandom_range(3, 12));
            for (int i = 0; i < n; i++) begin
                if (i == 0 || $urandom_range(0, 1) == 1)
                    do_idx(($urandom_range(0, 3) == 0) ? int'($urandom_range(NUM_TILES, 8191)) : int'($urandom_range(0, NUM_TILES - 1)));
                do_push(int'($urandom_range(0, 63)), acc);
            end
            @(negedge clk);
            n_checks++; if (int'(fifo_count) != mdl_qa.size()) begin n_errors++; $display("FAIL rand_count: got %0d expected %0d", fifo_count, mdl_qa.size()); end
            n_checks++; if (range_err !== mdl_rerr) begin n_errors++; $display("FAIL rand_range_err: got %0d expected %0d", range_err, mdl_rerr); end
            ok = 0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (busy === 1'b0) begin ok = 1; break; end
                vblank = $urandom_range(0, 1) == 1;
            end
            vblank = 1'b0;
            n_checks++; if (!ok) begin n_errors++; $display("FAIL rand_idle: got busy expected idle"); end
            n_checks++; if (obs_addr.size() != mdl_qa.size()) begin n_errors++; $display("FAIL rand_drain_count: got %0d expected %0d", obs_addr.size(), mdl_qa.size()); end
            bad = 0;
            for (int i = 0; i < obs_addr.size() && i < mdl_qa.size(); i++)
                if (obs_addr[i] != mdl_qa[i] || obs_data[i] != mdl_qd[i]) bad++;
            n_checks++; if (bad != 0) begin n_errors++; $display("FAIL rand_drain_order: got %0d bad entries expected 0", bad); end
            mdl_qa.delete(); mdl_qd.delete();
        end
    endtask

    task automatic test_fill();
        int sz, bad, gap_bad; bit ok;
        vblank = 1'b1;
        obs_clear();
        do_fill(10);
        for (int c = 0; c < 3000 && obs_addr.size() < 2000; c++) @(negedge clk);
        vblank = 1'b0;
        sz = obs_addr.size();
        n_checks++; if (sz != 2000) begin n_errors++; $display("FAIL fill_pause_at: got %0d expected 2000", sz); end
        repeat (100) @(negedge clk);
        n_checks++; if (obs_addr.size() != sz) begin n_errors++; $display("FAIL fill_paused: got %0d expected %0d", obs_addr.size(), sz); end
        vblank = 1'b1;
        wait_idle(6000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL fill_idle: got busy expected idle"); end
        n_checks++; if (obs_addr.size() != NUM_TILES) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", obs_addr.size(), NUM_TILES); end
        bad = 0; gap_bad = 0;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (obs_addr[i] != i || obs_data[i] != 10) bad++;
            if (i > 0 && i != 2000 && obs_cyc[i] != obs_cyc[i-1] + 1) gap_bad++;
            if (i == 2000 && obs_cyc[i] - obs_cyc[i-1] <= 100) gap_bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL fill_stream: got %0d bad entries expected 0", bad); end
        n_checks++; if (gap_bad != 0) begin n_errors++; $display("FAIL fill_timing: got %0d bad gaps expected 0", gap_bad); end
    endtask

    task automatic test_fill_discard();
        int acc, bad; bit ok;
        vblank = 1'b0;
        obs_clear();
        for (int i = 0; i < 3; i++) begin
            do_idx(int'($urandom_range(0, NUM_TILES - 1)));
            do_push(int'($urandom_range(0, 63)), acc);
        end
        do_fill(7);
        do_idx(3765);
        do_push(12, acc);
        @(negedge clk);
        n_checks++; if (int'(fifo_count) != mdl_qa.size()) begin n_errors++; $display("FAIL discard_count: got %0d expected %0d", fifo_count, mdl_qa.size()); end
        vblank = 1'b1;
        wait_idle(6000, ok);
        n_checks++; if (obs_addr.size() != NUM_TILES + mdl_qa.size()) begin
            n_errors++; $display("FAIL discard_total: got %0d expected %0d", obs_addr.size(), NUM_TILES + mdl_qa.size());
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (i < NUM_TILES) begin
                if (obs_addr[i] != i || obs_data[i] != 7) bad++;
            end else if (i - NUM_TILES < mdl_qa.size()) begin
                if (obs_addr[i] != mdl_qa[i-NUM_TILES] || obs_data[i] != mdl_qd[i-NUM_TILES]) bad++;
            end
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL discard_stream: got %0d bad entries expected 0", bad); end
        mdl_qa.delete(); mdl_qd.delete();
    endtask

    task automatic test_fill_restart();
        int a, b, k, bad; bit ok;
        a = int'($urandom_range(0, 31));
        b = a + 32;
        vblank = 1'b1;
        obs_clear();
        do_fill(a);
        for (int c = 0; c < 200 && obs_addr.size() < 50; c++) @(negedge clk);
        do_fill(b);
        wait_idle(6000, ok);
        k = obs_addr.size();
        for (int i = 0; i < obs_addr.size(); i++) if (obs_data[i] == b) begin k = i; break; end
        n_checks++; if (k < 50) begin n_errors++; $display("FAIL restart_first_len: got %0d expected >=50", k); end
        n_checks++; if (obs_addr.size() - k != NUM_TILES) begin n_errors++; $display("FAIL restart_second_len: got %0d expected %0d", obs_addr.size() - k, NUM_TILES); end
        bad = 0;
        for (int i = 0; i < obs_addr.size(); i++) begin
            if (i < k) begin if (obs_addr[i] != i || obs_data[i] != a) bad++; end
            else if (obs_addr[i] != i - k || obs_data[i] != b) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL restart_stream: got %0d bad entries expected 0", bad); end
    endtask

    task automatic test_index_mode();
        int acc, exp_second; bit ok;
        vblank = 1'b0;
        obs_clear();
`ifdef TILE_WRITER_AUTOINC_EN
        do_idx(NUM_TILES - 1);
        exp_second = 0;
`else
        do_idx(100);
        exp_second = 100;
`endif
        do_push(1, acc);
        do_push(2, acc);
        vblank = 1'b1;
        wait_idle(40, ok);
        n_checks++; if (obs_addr.size() != 2) begin n_errors++; $display("FAIL index_count: got %0d expected 2", obs_addr.size()); end
        if (obs_addr.size() == 2) begin
            n_checks++; if (obs_addr[0] != mdl_qa[0] || obs_data[0] != 1) begin
                n_errors++; $display("FAIL index_first: got (%0d,%0d) expected (%0d,1)", obs_addr[0], obs_data[0], mdl_qa[0]);
            end
            n_checks++; if (obs_addr[1] != exp_second || obs_data[1] != 2) begin
                n_errors++; $display("FAIL index_second: got (%0d,%0d) expected (%0d,2)", obs_addr[1], obs_data[1], exp_second);
            end
        end
        mdl_qa.delete(); mdl_qd.delete();
    endtask

    task automatic test_reset_midfill();
        int acc, sz;
        vblank = 1'b1;
        obs_clear();
        do_idx(6000);
        do_push(3, acc);
        do_fill(3);
        for (int c = 0; c < 2000 && obs_addr.size() < 1000; c++) @(negedge clk);
        do_idx(10);
        do_push(4, acc);
        @(negedge clk);
        n_checks++; if (range_err !== 1'b1) begin n_errors++; $display("FAIL pre_reset_range_err: got %0d expected 1", range_err); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (tm_we !== 1'b0) begin n_errors++; $display("FAIL midreset_tm_we: got %0d expected 0", tm_we); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %0d expected 0", busy); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errors++; $display("FAIL midreset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0 || range_err !== 1'b0) begin
            n_errors++; $display("FAIL midreset_flags: got %0d%0d expected 00", overflow, range_err);
        end
        reset = 1'b1;
        mdl_idx = 0; mdl_qa.delete(); mdl_qd.delete(); mdl_ovf = 0; mdl_rerr = 0;
        sz = obs_addr.size();
        repeat (20) @(negedge clk);
        n_checks++; if (obs_addr.size() != sz) begin n_errors++; $display("FAIL midreset_no_write: got %0d expected %0d", obs_addr.size(), sz); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_range();
        test_random_drain(4);
        test_index_mode();
        test_fill();
        test_fill_discard();
        test_fill_restart();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_writer.md
Name: tile_writer

Overview:
- Host-side front end for the tile-map display.
- Accepts Avalon-style register writes from the HPS and queues tile updates in a FIFO.
- Commits queued updates, and whole-screen fills, into the 4800-entry tile map (80x60 tiles of 8x8 px, 6-bit tile IDs) only during vertical blanking, so the display never tears.
- Sits directly upstream of the tile renderer and drives its tile-map write port.

Parameters:
- FIFO_DEPTH, 16, queued tile updates; power of two, ≥2.
- NUM_TILES, 4800, tile map entries; valid indices 0..NUM_TILES-1.
- IDX_W, 13, tile index width.
- ID_W, 6, tile ID width.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- writedata  in  16  host write data.
- write  in  1  host write strobe.
- chipselect  in  1  host select; a write is accepted only when write & chipselect.
- address  in  3  register select.
- vblank  in  1  high while the raster is outside the visible 640x480 area.
- tm_we  out  1  tile-map write enable.
- tm_addr  out  IDX_W  tile-map index.
- tm_data  out  ID_W  tile ID to store.
- busy  out  1  FIFO non-empty or fill in progress.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.
- range_err  out  1  sticky: a push was dropped because its index was ≥NUM_TILES.

Behaviour:
- Reset values: all outputs 0, FIFO empty, index register 0, state IDLE. Reset mid-fill or mid-drain aborts at once; no further tm_we.
- Register map (write-only):
  - addr 0: index register ← writedata[IDX_W-1:0].
  - addr 1: push {index register, writedata[ID_W-1:0]}.
  - addr 2: fill command, value writedata[ID_W-1:0].
  - addr 3: bit0=1 clears overflow and range_err.
  - addr 4..7: ignored.
- Push rules, checked in this order:
  - Index ≥NUM_TILES: dropped, range_err←1.
  - fifo_count==FIFO_DEPTH, sampled before any same-cycle pop: dropped, overflow←1.
  - Otherwise the entry is enqueued and fifo_count increments the next cycle.
- If a clear and a flag-setting event occur in the same cycle, the set wins.
- State machine, one tile-map write per cycle at most:
  - IDLE: fill pending → FILL; else FIFO non-empty → DRAIN.
  - DRAIN: each cycle with vblank==1 and FIFO non-empty, pop the head. The next cycle drives tm_we=1, tm_addr/tm_data = the entry. FIFO empty → IDLE. A pending fill preempts → FILL.
  - FILL: counter runs 0..NUM_TILES-1, one write per cycle while vblank==1, writing the fill value. vblank==0 pauses the counter. After index NUM_TILES-1 is written → IDLE.
- Outputs tm_we/tm_addr/tm_data are registered. A write appears in cycle k+1 only if vblank==1 was sampled at edge k. vblank falling therefore stops writes within one cycle; nothing is lost.
- Latency: push accepted at edge N with vblank high and FIFO empty → tm_we=1 at edge N+2.
- Fill command effects:
  - Discards all currently queued entries (fifo_count←0), since they would be overwritten.
  - Pushes after the fill command queue normally and drain after the fill completes.
  - A fill command during FILL restarts the fill from index 0 with the new value.
  - A fill and a push in the same cycle: the fill discards the old queue and the new push is kept.
- FIFO pointers wrap modulo FIFO_DEPTH.
- busy = (state != IDLE) | (fifo_count != 0).

Optional Feature:
- Macro TILE_WRITER_AUTOINC_EN.
- Defined: after every accepted or dropped addr-1 push, the index register increments by 1, wrapping NUM_TILES-1 → 0. This allows streaming a row of IDs after a single index write. An addr-0 write in the same cycle as a push takes priority over the increment.
- Undefined: the index register changes only on addr-0 writes.

Test Plan:
- vblank=1; write addr0=35, addr1=23 → tm_we=1, tm_addr=35, tm_data=23 exactly 2 cycles after the addr1 write; fifo_count returns to 0; busy falls.
- vblank=0; push 17 entries (FIFO_DEPTH=16) → fifo_count=16, overflow=1, no tm_we. Raise vblank → 16 writes in push order. Addr3=1 clears overflow.
- Write addr0=4800, addr1=5 → range_err=1, fifo_count=0, no tm_we.
- Fill with 10, vblank held high → 4800 consecutive tm_we, addresses 0..4799, data 10, then IDLE. Drop vblank for 100 cycles at index 2000 → writes pause and resume at 2000, none skipped or repeated.
- Queue 3 entries with vblank=0, then fill with 7, then push (3765,12); raise vblank → queued 3 never written; fill completes; then a single write (3765,12).
- Assert reset (0) mid-fill at index 1000 → next cycle tm_we=0, busy=0, fifo_count=0, flags 0. With TILE_WRITER_AUTOINC_EN: addr0=4799, push 1, push 2 → writes (4799,1), (0,2).
